// File: rtl/affine_interp_pkg.sv
// Shared constants and the 1/16-phase 6-tap coefficient table for affine_interp_6tap.
package affine_interp_pkg;

    localparam int NUM_TAPS   = 6;
    localparam int FRAC_BITS  = 4;
    localparam int NUM_PHASES = 16;
    localparam int NORM_SHIFT = 6;
    localparam int ROUND_OFS  = 32;

    typedef logic signed [7:0] coeff_t;

    // Row p is phase p, tap 0 weights the oldest sample; every row sums to 64.
    localparam coeff_t COEFF_TAB [NUM_PHASES][NUM_TAPS] = '{
        '{ 8'sd0,   8'sd0,   8'sd64,  8'sd0,   8'sd0,   8'sd0 },
        '{ 8'sd1,  -8'sd3,   8'sd63,  8'sd4,  -8'sd2,   8'sd1 },
        '{ 8'sd1,  -8'sd5,   8'sd62,  8'sd8,  -8'sd3,   8'sd1 },
        '{ 8'sd2,  -8'sd8,   8'sd60,  8'sd13, -8'sd4,   8'sd1 },
        '{ 8'sd3,  -8'sd10,  8'sd58,  8'sd17, -8'sd5,   8'sd1 },
        '{ 8'sd3,  -8'sd11,  8'sd52,  8'sd26, -8'sd8,   8'sd2 },
        '{ 8'sd2,  -8'sd9,   8'sd47,  8'sd31, -8'sd10,  8'sd3 },
        '{ 8'sd3,  -8'sd11,  8'sd45,  8'sd34, -8'sd10,  8'sd3 },
        '{ 8'sd3,  -8'sd11,  8'sd40,  8'sd40, -8'sd11,  8'sd3 },
        '{ 8'sd3,  -8'sd10,  8'sd34,  8'sd45, -8'sd11,  8'sd3 },
        '{ 8'sd3,  -8'sd10,  8'sd31,  8'sd47, -8'sd9,   8'sd2 },
        '{ 8'sd2,  -8'sd8,   8'sd26,  8'sd52, -8'sd11,  8'sd3 },
        '{ 8'sd1,  -8'sd5,   8'sd17,  8'sd58, -8'sd10,  8'sd3 },
        '{ 8'sd1,  -8'sd4,   8'sd13,  8'sd60, -8'sd8,   8'sd2 },
        '{ 8'sd1,  -8'sd3,   8'sd8,   8'sd62, -8'sd5,   8'sd1 },
        '{ 8'sd1,  -8'sd2,   8'sd4,   8'sd63, -8'sd3,   8'sd1 }
    };

endpackage

// File: rtl/affine_interp_6tap_mac.sv
// affine_tap_mac: S2 registers six table-weighted products, S3 registers their sum.
// With AFFINE_ROUND_CLIP_EN defined, S3 also rounds by 1/64 and saturates to IN_SIZE.
module affine_tap_mac
    import affine_interp_pkg::*;
#(
    parameter int IN_SIZE  = 8,
    parameter int ACC_SIZE = IN_SIZE + 8,
    parameter int OUT_SIZE = ACC_SIZE
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              en,
    input  logic [NUM_TAPS-1:0][IN_SIZE-1:0]  win_i,
    input  logic [FRAC_BITS-1:0]              frac_i,
    input  logic                              vld_i,
    output logic                              vld_o,
    output logic signed [OUT_SIZE-1:0]        data_o
);

    logic signed [ACC_SIZE-1:0] prod_d [NUM_TAPS];
    logic signed [ACC_SIZE-1:0] prod_q [NUM_TAPS];
    logic signed [ACC_SIZE-1:0] sum;
    logic signed [OUT_SIZE-1:0] data_d, data_q;
    logic                       vld2_q, vld3_q;

    always_comb begin
        for (int t = 0; t < NUM_TAPS; t++) begin
            prod_d[t] = ACC_SIZE'($signed(win_i[t])) * ACC_SIZE'(COEFF_TAB[frac_i][t]);
        end
    end

    always_comb begin
        sum = (prod_q[0] + prod_q[1]) + (prod_q[2] + prod_q[3]) + (prod_q[4] + prod_q[5]);
    end

`ifdef AFFINE_ROUND_CLIP_EN
    localparam logic signed [ACC_SIZE-1:0] SAT_MAX = ACC_SIZE'((1 << (IN_SIZE - 1)) - 1);
    localparam logic signed [ACC_SIZE-1:0] SAT_MIN = ~SAT_MAX;
    logic signed [ACC_SIZE-1:0] rnd;

    always_comb begin
        rnd = (sum + ACC_SIZE'(ROUND_OFS)) >>> NORM_SHIFT;
        if (rnd > SAT_MAX)      data_d = OUT_SIZE'(SAT_MAX);
        else if (rnd < SAT_MIN) data_d = OUT_SIZE'(SAT_MIN);
        else                    data_d = OUT_SIZE'(rnd);
    end
`else
    always_comb begin
        data_d = OUT_SIZE'(sum);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int t = 0; t < NUM_TAPS; t++) prod_q[t] <= '0;
            vld2_q <= 1'b0;
            vld3_q <= 1'b0;
            data_q <= '0;
        end else if (en) begin
            for (int t = 0; t < NUM_TAPS; t++) prod_q[t] <= prod_d[t];
            vld2_q <= vld_i;
            vld3_q <= vld2_q;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld3_q;
    assign data_o = data_q;

endmodule

// File: rtl/affine_interp_6tap.sv
// Streaming 6-tap 1/16-phase affine interpolator: sliding window, fill counter, S1 snapshot.
// Optional macro AFFINE_ROUND_CLIP_EN: round/saturate output to IN_SIZE instead of raw sum.
module affine_interp_6tap
    import affine_interp_pkg::*;
#(
    parameter int IN_SIZE  = 8,
    parameter int ACC_SIZE = IN_SIZE + 8,
`ifdef AFFINE_ROUND_CLIP_EN
    parameter int OUT_SIZE = IN_SIZE
`else
    parameter int OUT_SIZE = ACC_SIZE
`endif
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_SIZE-1:0]   in_sample,
    input  logic [FRAC_BITS-1:0]        in_frac,
    input  logic                        in_sol,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_SIZE-1:0]  out_data
);

    logic                             adv, accept, launch;
    logic [NUM_TAPS-1:0][IN_SIZE-1:0] win_d, win_q, s1_win_d, s1_win_q;
    logic [2:0]                       cnt_d, cnt_q, cnt_base;
    logic [FRAC_BITS-1:0]             s1_frac_d, s1_frac_q;
    logic                             s1_vld_d, s1_vld_q;

    // Whole pipeline, window included, freezes while a result waits downstream.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    always_comb begin
        win_d     = win_q;
        cnt_d     = cnt_q;
        cnt_base  = in_sol ? 3'd0 : cnt_q;
        launch    = 1'b0;
        s1_win_d  = s1_win_q;
        s1_frac_d = s1_frac_q;
        s1_vld_d  = s1_vld_q;
        if (accept) begin
            win_d  = {in_sample, win_q[NUM_TAPS-1:1]};
            cnt_d  = (cnt_base == 3'(NUM_TAPS)) ? cnt_base : cnt_base + 3'd1;
            launch = (cnt_d == 3'(NUM_TAPS));
        end
        if (adv) begin
            s1_win_d  = win_d;
            s1_frac_d = in_frac;
            s1_vld_d  = launch;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q     <= '0;
            cnt_q     <= '0;
            s1_win_q  <= '0;
            s1_frac_q <= '0;
            s1_vld_q  <= 1'b0;
        end else begin
            win_q     <= win_d;
            cnt_q     <= cnt_d;
            s1_win_q  <= s1_win_d;
            s1_frac_q <= s1_frac_d;
            s1_vld_q  <= s1_vld_d;
        end
    end

    affine_tap_mac #(
        .IN_SIZE  (IN_SIZE),
        .ACC_SIZE (ACC_SIZE),
        .OUT_SIZE (OUT_SIZE)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (adv),
        .win_i  (s1_win_q),
        .frac_i (s1_frac_q),
        .vld_i  (s1_vld_q),
        .vld_o  (out_valid),
        .data_o (out_data)
    );

endmodule

// File: tb/tb_affine_interp_6tap.sv
// Scoreboard bench for affine_interp_6tap: driver pushes expected results, negedge monitor pops.
`timescale 1ns/1ps
module tb_affine_interp_6tap;

    localparam int IN_SIZE  = 8;
    localparam int ACC_SIZE = IN_SIZE + 8;
`ifdef AFFINE_ROUND_CLIP_EN
    localparam int OUT_SIZE = IN_SIZE;
`else
    localparam int OUT_SIZE = ACC_SIZE;
`endif

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       in_valid = 1'b0;
    logic                       in_ready;
    logic signed [IN_SIZE-1:0]  in_sample = '0;
    logic [3:0]                 in_frac = '0;
    logic                       in_sol = 1'b0;
    logic                       out_valid;
    logic                       out_ready = 1'b1;
    logic signed [OUT_SIZE-1:0] out_data;

    affine_interp_6tap dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sample (in_sample),
        .in_frac   (in_frac),
        .in_sol    (in_sol),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    val;
        int    cyc;
        bit    chk_lat;
        string tag;
    } exp_t;

    exp_t sbq[$];
    int   hist[$];
    int   fill = 0;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   win_a[6];

    always @(posedge clk) cyc++;

    function automatic int pick(input int raw, input int clp);
`ifdef AFFINE_ROUND_CLIP_EN
        return clp;
`else
        return raw;
`endif
    endfunction

    // Phase 0 passes the sample three beats back straight through with gain 64.
    task automatic send(input int s, input int f, input bit sol, input bit has_exp,
                        input int expv, input string tag, input bit chk_lat);
        bit took;
        exp_t e;
        in_valid  = 1'b1;
        in_sample = IN_SIZE'(s);
        in_frac   = 4'(f);
        in_sol    = sol;
        took      = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                took = 1'b1;
                break;
            end
        end
        if (!took) begin
            total++;
            bad++;
            $display("FAIL %s accept_timeout got=in_ready_low exp=accept", tag);
        end else begin
            hist.push_back(s);
            if (hist.size() > 6) void'(hist.pop_front());
            if (sol) fill = 0;
            if (fill < 6) fill++;
            if (fill == 6) begin
                e.val     = has_exp ? expv : pick(64 * hist[2], hist[2]);
                e.cyc     = cyc + 3;
                e.chk_lat = chk_lat;
                e.tag     = tag;
                sbq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sol   = 1'b0;
    endtask

    task automatic line6(input int w[6], input int f, input int expv, input string tag,
                         input bit chk_lat);
        for (int i = 0; i < 6; i++) send(w[i], f, i == 0, 1'b1, expv, tag, chk_lat && i == 5);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    exp_t mon_e;
    int   got;
    int   held;
    bit   stall_prev = 1'b0;

    always @(negedge clk) begin
        if (rst_n && out_valid && !out_ready) begin
            total++;
            if (in_ready !== 1'b0) begin
                bad++;
                $display("FAIL stall_in_ready got=%0b exp=0", in_ready);
            end
            if (stall_prev) begin
                total++;
                if (int'(out_data) != held) begin
                    bad++;
                    $display("FAIL stall_hold got=%0d exp=%0d", out_data, held);
                end
            end
            held = int'(out_data);
            stall_prev = 1'b1;
        end else begin
            stall_prev = 1'b0;
        end
        if (rst_n && out_valid && out_ready) begin
            total++;
            got = int'(out_data);
            if (sbq.size() == 0) begin
                bad++;
                $display("FAIL unexpected_out got=%0d exp=no_result", got);
            end else begin
                mon_e = sbq.pop_front();
                if (got != mon_e.val) begin
                    bad++;
                    $display("FAIL %s got=%0d exp=%0d", mon_e.tag, got, mon_e.val);
                end
                if (mon_e.chk_lat) begin
                    total++;
                    if (cyc != mon_e.cyc) begin
                        bad++;
                        $display("FAIL %s_latency got=%0d exp=%0d", mon_e.tag, cyc, mon_e.cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input int g, input int x);
        total++;
        if (g != x) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, g, x);
        end
    endtask

    initial begin
        #12;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        win_a = '{10, 10, 10, 10, 10, 10};
        line6(win_a, 0, pick(640, 10), "ph0_const10", 1'b1);
        idle(8);

        win_a = '{0, 0, 0, 64, 64, 64};
        line6(win_a, 8, pick(2048, 32), "ph8_step", 1'b0);
        send(64, 8, 1'b0, 1'b1, pick(4608, 72), "ph8_step7", 1'b0);
        idle(6);

        win_a = '{127, -128, 127, 127, -128, 127};
        line6(win_a, 8, pick(13738, 127), "ph8_sat_pos", 1'b0);
        win_a = '{-128, 127, -128, -128, 127, -128};
        line6(win_a, 8, pick(-13802, -128), "ph8_sat_neg", 1'b0);
        win_a = '{1, 2, 3, 4, 5, 6};
        line6(win_a, 1, pick(196, 3), "ph1_ramp", 1'b0);
        line6(win_a, 15, pick(252, 4), "ph15_ramp", 1'b0);
        line6(win_a, 4, pick(206, 3), "ph4_ramp", 1'b0);
        idle(6);

        // Back-to-back stream with a 4-cycle downstream stall in the middle.
        fork
            begin
                for (int i = 0; i < 20; i++) send(i * 7 - 50, 0, i == 0, 1'b0, 0, "stream", 1'b0);
            end
            begin
                repeat (10) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        idle(6);

        for (int i = 0; i < 16; i++) send(100 - i * 9, 0, i == 0 || i == 8, 1'b0, 0, "sol_restart", 1'b0);
        idle(6);

        for (int i = 0; i < 8; i++) send(i * 5 + 3, 0, i == 0, 1'b0, 0, "pre_reset", 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", int'(out_valid), 0);
        chk("async_rst_out_data", int'(out_data), 0);
        sbq.delete();
        hist.delete();
        fill = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) send(i * 11 - 20, 0, 1'b0, 1'b0, 0, "post_reset", 1'b0);
        idle(8);

        chk("scoreboard_empty", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
